pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage MIPS core; replaces the fixed F/D latch.

---
 rtl/pipe_stage_reg_pkg.sv | 38 +++
 rtl/pipe_stage_reg_sat_counter.sv | 28 ++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage registers: exception codes,
// reset/handler addresses, the NOP word and the per-edge action encoding.
package pipe_stage_reg_pkg;

  // Exception codes carried down the pipe (0 = no exception)
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] ADDR_RESET   = 32'h0000_3000;
  localparam logic [31:0] ADDR_HANDLER = 32'h0000_4180;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  // What the register does on a given edge, in priority order
  typedef enum logic [2:0] {
    ACT_RESET = 3'd0,
    ACT_REQ   = 3'd1,
    ACT_FLUSH = 3'd2,
    ACT_STALL = 3'd3,
    ACT_LOAD  = 3'd4
  } act_e;

  // Fixed priority: reset > req > flush > stall > load
  function automatic act_e sel_action(input logic rst, input logic rq,
                                      input logic fl, input logic st);
    if (rst)     return ACT_RESET;
    else if (rq) return ACT_REQ;
    else if (fl) return ACT_FLUSH;
    else if (st) return ACT_STALL;
    else         return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: counts up on i_inc, sticks at all-ones,
// i_clr zeroes it and takes precedence over the increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count register: reset and clear dominate, increment only below saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage core. Carries PC, instruction,
// branch-delay flag and exception code with hold, bubble and exception-entry
// control, an optional fetch-address check and stall/bubble statistics.
module pipe_stage_reg #(
  parameter int                 PC_W       = 32,
  parameter int                 INSTR_W    = 32,
  parameter int                 EXC_W      = 5,
  parameter logic [PC_W-1:0]    RESET_PC   = PC_W'(pipe_stage_reg_pkg::ADDR_RESET),
  parameter logic [PC_W-1:0]    HANDLER_PC = PC_W'(pipe_stage_reg_pkg::ADDR_HANDLER),
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(pipe_stage_reg_pkg::NOP_WORD),
  parameter bit                 KEEP_PC    = 1'b1,
  parameter bit                 CHK_ADDR   = 1'b0,
  parameter logic [PC_W-1:0]    IMEM_LO    = PC_W'(32'h0000_3000),
  parameter logic [PC_W-1:0]    IMEM_HI    = PC_W'(32'h0000_6ffc),
  parameter logic [EXC_W-1:0]   EXC_ADEL   = EXC_W'(pipe_stage_reg_pkg::EXC_ADEL),
  parameter int                 CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               req,
  input  logic               cnt_clr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_bd,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_bd,
  output logic [EXC_W-1:0]   out_exc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  import pipe_stage_reg_pkg::*;

  // A fetch address is illegal if misaligned or outside instruction memory
  function automatic logic addr_bad(input logic [PC_W-1:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
  endfunction

  act_e               w_act;
  logic               w_valid_next;
  logic [PC_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0] w_instr_next;
  logic               w_bd_next;
  logic [EXC_W-1:0]   w_exc_next;
  logic               w_stall_win;
  logic               w_bubble_win;

  logic               r_valid;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_bd;
  logic [EXC_W-1:0]   r_exc;

  // Pick the winning action and build the next payload (default: hold)
  always_comb begin
    w_act        = sel_action(reset, req, flush, stall);
    w_valid_next = r_valid;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_bd_next    = r_bd;
    w_exc_next   = r_exc;
    case (w_act)
      ACT_RESET: begin
        w_valid_next = 1'b0;
        w_pc_next    = RESET_PC;
        w_instr_next = NOP_INSTR;
        w_bd_next    = 1'b0;
        w_exc_next   = '0;
      end
      ACT_REQ: begin
        w_valid_next = 1'b0;
        w_pc_next    = HANDLER_PC;
        w_instr_next = NOP_INSTR;
        w_bd_next    = 1'b0;
        w_exc_next   = '0;
      end
      ACT_FLUSH: begin
        // Bubble keeps the upstream PC so a later exception still has an EPC
        w_valid_next = 1'b0;
        w_instr_next = NOP_INSTR;
        w_exc_next   = '0;
        if (KEEP_PC) begin
          w_pc_next = in_pc;
          w_bd_next = in_bd;
        end else begin
          w_pc_next = RESET_PC;
          w_bd_next = 1'b0;
        end
      end
      ACT_STALL: begin
        w_valid_next = r_valid;
      end
      ACT_LOAD: begin
        w_valid_next = 1'b1;
        w_pc_next    = in_pc;
        w_instr_next = in_instr;
        w_bd_next    = in_bd;
        w_exc_next   = in_exc;
        // An earlier upstream exception has priority over the fetch fault
        if (CHK_ADDR && (in_exc == '0) && addr_bad(in_pc)) begin
          w_exc_next   = EXC_ADEL;
          w_instr_next = NOP_INSTR;
        end
      end
      default: begin
        w_valid_next = r_valid;
      end
    endcase
  end

  // Payload register; reset values come straight from the reset action
  always_ff @(posedge clk) begin
    r_valid <= w_valid_next;
    r_pc    <= w_pc_next;
    r_instr <= w_instr_next;
    r_bd    <= w_bd_next;
    r_exc   <= w_exc_next;
  end

  assign w_stall_win  = (w_act == ACT_STALL);
  assign w_bubble_win = (w_act == ACT_FLUSH);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_win),
    .i_clr   (cnt_clr),
    .o_count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_bubble_win),
    .i_clr   (cnt_clr),
    .o_count (bubble_cnt)
  );

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign out_instr = r_instr;
  assign out_bd    = r_bd;
  assign out_exc   = r_exc;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (fetch-address check on, 4-bit counters).
// The driver pushes the hand-computed expected state into a queue tagged with
// the cycle it becomes visible; the monitor pops and compares on the falling edge.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset, stall, flush, req, cnt_clr;
  logic [31:0] in_pc, in_instr;
  logic        in_bd;
  logic [4:0]  in_exc;
  logic        out_valid, out_bd;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  out_exc;
  logic [3:0]  stall_cnt, bubble_cnt;

  pipe_stage_reg #(.CHK_ADDR(1'b1), .KEEP_PC(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .req(req),
    .cnt_clr(cnt_clr), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd),
    .in_exc(in_exc), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_bd(out_bd), .out_exc(out_exc),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    int          due;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc;
    logic [3:0]  sc;
    logic [3:0]  bc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry whose output is due by this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (out_valid !== e.v || out_pc !== e.pc || out_instr !== e.instr ||
          out_bd !== e.bd || out_exc !== e.exc || stall_cnt !== e.sc ||
          bubble_cnt !== e.bc) begin
        miscompares = miscompares + 1;
        $display("FAIL vec%0d: got v=%0b pc=%h ins=%h bd=%0b exc=%0d sc=%0d bc=%0d, want v=%0b pc=%h ins=%h bd=%0b exc=%0d sc=%0d bc=%0d",
                 vectors, out_valid, out_pc, out_instr, out_bd, out_exc, stall_cnt, bubble_cnt,
                 e.v, e.pc, e.instr, e.bd, e.exc, e.sc, e.bc);
      end else begin
        $display("vec%0d ok: v=%0b pc=%h ins=%h bd=%0b exc=%0d sc=%0d bc=%0d",
                 vectors, out_valid, out_pc, out_instr, out_bd, out_exc, stall_cnt, bubble_cnt);
      end
    end
  end

  task automatic drive(input logic rst, input logic rq, input logic fl, input logic st,
                       input logic clr, input logic [31:0] pc, input logic [31:0] ins,
                       input logic bd, input logic [4:0] exc);
    reset = rst; req = rq; flush = fl; stall = st; cnt_clr = clr;
    in_pc = pc; in_instr = ins; in_bd = bd; in_exc = exc;
  endtask

  // Push the expectation for the next edge, then advance one cycle
  task automatic expect_step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic bd, input logic [4:0] exc,
                             input logic [3:0] sc, input logic [3:0] bc);
    exp_t e;
    e.due = cyc + 1; e.v = v; e.pc = pc; e.instr = ins; e.bd = bd;
    e.exc = exc; e.sc = sc; e.bc = bc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 5'd0);
    @(posedge clk);
    #1;
    // Reset for two cycles
    repeat (2) begin
      drive(1, 0, 0, 0, 0, 32'h5555, 32'hdead_beef, 1, 5'd3);
      expect_step(0, 32'h3000, 32'h0, 0, 5'd0, 4'd0, 4'd0);
    end
    // Plain load
    drive(0, 0, 0, 0, 0, 32'h3004, 32'h3c01_0001, 0, 5'd0);
    expect_step(1, 32'h3004, 32'h3c01_0001, 0, 5'd0, 4'd0, 4'd0);
    // Three stalls with changing inputs: payload held, stall_cnt counts
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 1, 0, 32'h3008 + 32'(k), 32'h1111_1111, 1, 5'd3);
      expect_step(1, 32'h3004, 32'h3c01_0001, 0, 5'd0, 4'(k), 4'd0);
    end
    // Flush beats stall; bubble keeps in_pc/in_bd
    drive(0, 0, 1, 1, 0, 32'h3010, 32'h2222_2222, 1, 5'd5);
    expect_step(0, 32'h3010, 32'h0, 1, 5'd0, 4'd3, 4'd1);
    // req beats flush and stall, no counting
    drive(0, 1, 1, 1, 0, 32'h3014, 32'h3333_3333, 1, 5'd6);
    expect_step(0, 32'h4180, 32'h0, 0, 5'd0, 4'd3, 4'd1);
    // Flush alone
    drive(0, 0, 1, 0, 0, 32'h3018, 32'h4444_4444, 0, 5'd0);
    expect_step(0, 32'h3018, 32'h0, 0, 5'd0, 4'd3, 4'd2);
    // Fetch-address check: misaligned, above, below, legal edge, upstream exc kept
    drive(0, 0, 0, 0, 0, 32'h3002, 32'h1234_5678, 0, 5'd0);
    expect_step(1, 32'h3002, 32'h0, 0, 5'd4, 4'd3, 4'd2);
    drive(0, 0, 0, 0, 0, 32'h7000, 32'h0000_0001, 0, 5'd0);
    expect_step(1, 32'h7000, 32'h0, 0, 5'd4, 4'd3, 4'd2);
    drive(0, 0, 0, 0, 0, 32'h3000, 32'h0000_000c, 0, 5'd10);
    expect_step(1, 32'h3000, 32'h0000_000c, 0, 5'd10, 4'd3, 4'd2);
    drive(0, 0, 0, 0, 0, 32'h2ffc, 32'h0000_0005, 0, 5'd0);
    expect_step(1, 32'h2ffc, 32'h0, 0, 5'd4, 4'd3, 4'd2);
    drive(0, 0, 0, 0, 0, 32'h6ffc, 32'h0000_00aa, 1, 5'd0);
    expect_step(1, 32'h6ffc, 32'h0000_00aa, 1, 5'd0, 4'd3, 4'd2);
    drive(0, 0, 0, 0, 0, 32'h7000, 32'h0000_00bb, 0, 5'd12);
    expect_step(1, 32'h7000, 32'h0000_00bb, 0, 5'd12, 4'd3, 4'd2);
    // Clear beats the stall increment
    drive(0, 0, 0, 1, 1, 32'h3100, 32'h9999_9999, 1, 5'd0);
    expect_step(1, 32'h7000, 32'h0000_00bb, 0, 5'd12, 4'd0, 4'd0);
    // 20 stalls: stall_cnt saturates at 4'hf
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 1, 0, 32'h3200, 32'h8888_8888, 0, 5'd0);
      expect_step(1, 32'h7000, 32'h0000_00bb, 0, 5'd12, (k > 15) ? 4'hf : 4'(k), 4'd0);
    end
    drive(0, 0, 0, 1, 1, 32'h3200, 32'h8888_8888, 0, 5'd0);
    expect_step(1, 32'h7000, 32'h0000_00bb, 0, 5'd12, 4'd0, 4'd0);
    // Clear beats the bubble increment
    drive(0, 0, 1, 0, 1, 32'h3030, 32'h7777_7777, 1, 5'd2);
    expect_step(0, 32'h3030, 32'h0, 1, 5'd0, 4'd0, 4'd0);
    drive(0, 0, 1, 0, 0, 32'h3034, 32'h7777_7777, 0, 5'd0);
    expect_step(0, 32'h3034, 32'h0, 0, 5'd0, 4'd0, 4'd1);
    drive(0, 0, 0, 1, 0, 32'h3038, 32'h6666_6666, 1, 5'd1);
    expect_step(0, 32'h3034, 32'h0, 0, 5'd0, 4'd1, 4'd1);
    // Reset during stall and flush returns to reset values
    drive(1, 0, 1, 1, 0, 32'h3040, 32'h6666_6666, 1, 5'd1);
    expect_step(0, 32'h3000, 32'h0, 0, 5'd0, 4'd0, 4'd0);
    drive(0, 0, 0, 0, 0, 32'h3044, 32'h0000_0010, 0, 5'd0);
    expect_step(1, 32'h3044, 32'h0000_0010, 0, 5'd0, 4'd0, 4'd0);

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
